rc6_key_expander: RTL
=====================

# rc6_key_expander

Control and datapath stage that drives the RC6 key register through the full RC6-32/20/32 key schedule. It latches a 256-bit user key and clears the key register back to the P32/Q32 constants. It loads L, then runs 132 mixing iterations (3·max(44,8)), one per clock. Each iteration feeds the new S[i] and L[j] back into the register's internal write port. It sits directly upstream of the key register. The encrypt/decrypt round logic consumes the expanded subkeys once `outReady` is high.

## Interface
Parameters:
- `ITERATIONS`, 132: mixing iterations, 3·max(t=44, c=8).
- `CNT_W`, 8: iteration counter width; must satisfy 2^CNT_W > ITERATIONS.

Ports:
- `inClk`  in  1  single clock, rising edge.
- `inReset`  in  1  synchronous, active-high reset.
- `inStart`  in  1  start request; sampled only in IDLE or DONE.
- `inKey`  in  256  user key, byte order as supplied to the key register's external port.
- `inSregValue`  in  32  current S[i] from the key register.
- `inLregValue`  in  32  current L[j] from the key register.
- `inAdata`  in  32  key register A.
- `inBdata`  in  32  key register B.
- `outKeyClr`  out  1  one-cycle clear of the key register. At top level it is ORed with `inReset` into the register's reset.
- `outExtWr`  out  1  one-cycle external key write strobe.
- `outExtKey`  out  256  latched key; stable from LOAD to the next start.
- `outIntWr`  out  1  internal write strobe, high for every MIX cycle.
- `outSvalue`  out  32  new S[i] (combinational).
- `outLvalue`  out  32  new L[j] (combinational).
- `outBusy`  out  1  high in CLEAR, LOAD and MIX.
- `outDone`  out  1  one-cycle pulse on entry to DONE.
- `outReady`  out  1  level; high in DONE.

## Operation
- FSM states: IDLE, CLEAR, LOAD, MIX, DONE.
- IDLE/DONE + `inStart`=1: latch `inKey` into `outExtKey`, counter←0, go to CLEAR.
- CLEAR: `outKeyClr`=1 for one cycle. This restores the S constants and zeroes L, A and B. Next state is LOAD.
- LOAD: `outExtWr`=1 for one cycle. Next state is MIX.
- MIX: `outIntWr`=1 and counter increments every cycle. When the counter reaches ITERATIONS−1, the next state is DONE. `outDone`=1 on that transition.
- DONE: `outReady`=1, holding until `inStart` or `inReset`. The key register then holds S[0..43].
- `inStart` in CLEAR, LOAD or MIX is ignored. No restart and no queueing.
- Per-iteration arithmetic (all mod 2^32, rotations on 32 bits):
  - `outSvalue` = ROTL(inSregValue + inAdata + inBdata, 3).
  - `outLvalue` = ROTL(inLregValue + outSvalue + inBdata, (outSvalue + inBdata)[4:0]).
  - The rotation amount uses only the low 5 bits of the 32-bit sum.
- The key register shifts S (44 words) and L (8 words) on each internal write. Index wrap (i mod 44, j mod 8) is therefore implicit; the block keeps no index counters for i or j.
- Reset values: state=IDLE, counter=0, `outExtKey`=0. All strobes, `outBusy`, `outDone` and `outReady` are 0.
- `inReset` mid-operation: return to IDLE on the next edge with all strobes low. The key register is reset by the same signal.

## Timing
- Start at edge N: CLEAR during N+1, LOAD during N+2, MIX during N+3 … N+134.
- `outDone` and `outReady` are first high in cycle N+135. Total latency is 135 cycles from start to ready.
- `outSvalue`/`outLvalue` are combinational from key-register outputs that are registered. The feedback loop is exactly one clock: three 32-bit adders and two rotators.
- Strobes are registered FSM decodes. No strobe is ever asserted together with another.
- `outExtKey` changes only on an accepted start.

## Structure
- Shared package `rc6_pkg`:
  - constants `RC6_W`=32, `RC6_T`=44, `RC6_C`=8, `RC6_ITER`=132, P32=B7E15163, Q32=9E3779B9;
  - FSM state encoding;
  - a ROTL function.
- One sub-module, `rc6_key_mix`: the purely combinational S/L update (four 32-bit inputs, two 32-bit outputs). It is reusable by a software-matching reference checker.

## Test plan
- Zero key, start pulse. First MIX cycle, with S=B7E15163 and A=B=0, gives `outSvalue`=BF0A8B1D and `outLvalue`=B7E15163. `outIntWr` is high for exactly 132 cycles, and `outDone` pulses at start+135.
- Key 0x0123…EF (32 bytes): final S[0..43] in the key register matches the C reference model word-for-word. S[0], S[1], S[42] and S[43] are checked at the register outputs.
- `inStart` asserted again at MIX cycle 50: ignored; the counter and the final result are identical to the uninterrupted run.
- `inReset` at MIX cycle 70: next cycle state=IDLE, all strobes 0, `outReady`=0. A subsequent start yields the correct schedule.
- Back-to-back keys: a second start in DONE with a different key produces a `outKeyClr` pulse. The result equals the model for the second key and is independent of the first.
- Rotation boundary: force (S'+B)[4:0]=0 and =31 via directed register values. `outLvalue` equals an unrotated sum and a rotate-right by 1 respectively.

Source files
------------

// File: rtl/rc6_pkg.sv
// Shared RC6-32/20/32 constants, key-expander FSM encoding and word rotate helper.
// Pure definitions: no logic, no latency, no flow control.
package rc6_pkg;

    localparam int RC6_W     = 32;
    localparam int RC6_T     = 44;
    localparam int RC6_C     = 8;
    localparam int RC6_ITER  = 132;
    localparam int RC6_KEY_W = 256;

    localparam logic [RC6_W-1:0] RC6_P32 = 32'hB7E15163;
    localparam logic [RC6_W-1:0] RC6_Q32 = 32'h9E3779B9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_MIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Rotate via a doubled word so a zero amount needs no special case.
    function automatic logic [RC6_W-1:0] rotl(input logic [RC6_W-1:0] x, input logic [4:0] n);
        logic [2*RC6_W-1:0] w_dbl;
        w_dbl = {x, x} << n;
        return w_dbl[2*RC6_W-1:RC6_W];
    endfunction

endpackage

// File: rtl/rc6_key_mix.sv
// One RC6 key-schedule step: new S[i] and L[j] from the current S, L, A and B words.
// Purely combinational, zero latency, no flow control.
module rc6_key_mix
    import rc6_pkg::*;
(
    input  logic [RC6_W-1:0] inSreg,
    input  logic [RC6_W-1:0] inLreg,
    input  logic [RC6_W-1:0] inA,
    input  logic [RC6_W-1:0] inB,
    output logic [RC6_W-1:0] outS,
    output logic [RC6_W-1:0] outL
);

    logic [RC6_W-1:0] w_s_sum;
    logic [RC6_W-1:0] w_rot_sum;
    logic [RC6_W-1:0] w_l_sum;

    always_comb begin
        w_s_sum   = inSreg + inA + inB;
        outS      = rotl(w_s_sum, 5'd3);
        // S'+B is both the rotate amount source and a partial term of the L sum.
        w_rot_sum = outS + inB;
        w_l_sum   = inLreg + w_rot_sum;
        outL      = rotl(w_l_sum, w_rot_sum[4:0]);
    end

endmodule

// File: rtl/rc6_key_expander.sv
// Sequences the RC6 key register through clear, key load and 132 mixing writes.
// Start to outReady is 135 cycles; starts outside IDLE/DONE are dropped, nothing is queued.
module rc6_key_expander
    import rc6_pkg::*;
#(
    parameter int ITERATIONS = RC6_ITER,
    parameter int CNT_W      = 8
) (
    input  logic                 inClk,
    input  logic                 inReset,
    input  logic                 inStart,
    input  logic [RC6_KEY_W-1:0] inKey,
    input  logic [RC6_W-1:0]     inSregValue,
    input  logic [RC6_W-1:0]     inLregValue,
    input  logic [RC6_W-1:0]     inAdata,
    input  logic [RC6_W-1:0]     inBdata,
    output logic                 outKeyClr,
    output logic                 outExtWr,
    output logic [RC6_KEY_W-1:0] outExtKey,
    output logic                 outIntWr,
    output logic [RC6_W-1:0]     outSvalue,
    output logic [RC6_W-1:0]     outLvalue,
    output logic                 outBusy,
    output logic                 outDone,
    output logic                 outReady
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_key_ld;
    logic [RC6_KEY_W-1:0]   r_ext_key;
    logic                   r_key_clr;
    logic                   r_ext_wr;
    logic                   r_int_wr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_key_ld    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (inStart) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                    w_key_ld    = 1'b1;
                end
            end
            ST_CLEAR: w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_MIX;
            ST_MIX: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so each one lines up with its state cycle.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ext_key <= '0;
            r_key_clr <= 1'b0;
            r_ext_wr  <= 1'b0;
            r_int_wr  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_key_ld) begin
                r_ext_key <= inKey;
            end
            r_key_clr <= (w_state_nxt == ST_CLEAR);
            r_ext_wr  <= (w_state_nxt == ST_LOAD);
            r_int_wr  <= (w_state_nxt == ST_MIX);
            r_busy    <= (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_LOAD) ||
                         (w_state_nxt == ST_MIX);
            r_done    <= (r_state == ST_MIX) && (w_state_nxt == ST_DONE);
            r_ready   <= (w_state_nxt == ST_DONE);
        end
    end

    rc6_key_mix u_mix (
        .inSreg (inSregValue),
        .inLreg (inLregValue),
        .inA    (inAdata),
        .inB    (inBdata),
        .outS   (outSvalue),
        .outL   (outLvalue)
    );

    assign outKeyClr = r_key_clr;
    assign outExtWr  = r_ext_wr;
    assign outExtKey = r_ext_key;
    assign outIntWr  = r_int_wr;
    assign outBusy   = r_busy;
    assign outDone   = r_done;
    assign outReady  = r_ready;

endmodule
